score_reset_char_rom: RTL

SCORE_RESET_CHAR_ROM -- requirements
Module: score_reset_char_rom

---
 rtl/score_reset_char_rom_if.sv | 22 ++
 rtl/score_reset_char_rom.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/score_reset_char_rom_if.sv
// Character-lookup and score bus between the display controller and the score text ROM.
interface score_reset_char_rom_if #(
  parameter int SCORE_BITS = 14
) ();
  logic [7:0]            char_yx;
  logic [7:0]            char_line;
  logic [SCORE_BITS-1:0] score;
  logic                  game_over;
  logic                  victory;
  logic [31:0]           char_pixels;
  logic                  bcd_busy;

  modport master (
    output char_yx, char_line, score, game_over, victory,
    input  char_pixels, bcd_busy
  );

  modport slave (
    input  char_yx, char_line, score, game_over, victory,
    output char_pixels, bcd_busy
  );
endinterface

// File: rtl/score_reset_char_rom.sv
// End-of-game text renderer: 3-register char-cell to 32x32 glyph pipeline, plus a
// double-dabble converter that latches the score as 4 BCD digits for the "SCORE dddd" line.
module score_reset_char_rom #(
  parameter int SCORE_MAX  = 9999,
  parameter int SCORE_BITS = 14
) (
  input logic                   pclk,
  input logic                   rst,
  score_reset_char_rom_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  localparam logic [SCORE_BITS-1:0] SCORE_CAP = SCORE_BITS'(SCORE_MAX);
  localparam int                    CNT_W     = $clog2(SCORE_BITS + 1);
  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(SCORE_BITS - 1);

  function automatic logic [SCORE_BITS-1:0] sat_score(input logic [SCORE_BITS-1:0] s);
    return (s > SCORE_CAP) ? SCORE_CAP : s;
  endfunction

  function automatic logic [15:0] dabble_adj(input logic [15:0] b);
    logic [15:0] r;
    for (int i = 0; i < 4; i++)
      r[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? b[4*i +: 4] + 4'd3 : b[4*i +: 4];
    return r;
  endfunction

  // Glyph lines 0..15 packed MSB-first; unlisted codes (including space) are blank.
  function automatic logic [127:0] glyph(input logic [7:0] code);
    case (code)
      8'h30:   return 128'h00007CC6C6CEDEF6E6C6C67C00000000;
      8'h31:   return 128'h00001838781818181818187E00000000;
      8'h32:   return 128'h00007CC6060C183060C0C6FE00000000;
      8'h33:   return 128'h00007CC606063C060606C67C00000000;
      8'h34:   return 128'h00000C1C3C6CCCFE0C0C0C1E00000000;
      8'h35:   return 128'h0000FEC0C0C0FC060606C67C00000000;
      8'h36:   return 128'h00003860C0C0FCC6C6C6C67C00000000;
      8'h37:   return 128'h0000FEC606060C183030303000000000;
      8'h38:   return 128'h00007CC6C6C67CC6C6C6C67C00000000;
      8'h39:   return 128'h00007CC6C6C67E0606060C7800000000;
      8'h41:   return 128'h000010386CC6C6FEC6C6C6C600000000;
      8'h43:   return 128'h00003C66C2C0C0C0C0C2663C00000000;
      8'h45:   return 128'h0000FE6662687868606266FE00000000;
      8'h47:   return 128'h00003C66C2C0C0DEC6C6663A00000000;
      8'h49:   return 128'h00003C18181818181818183C00000000;
      8'h4D:   return 128'h0000C6EEFEFED6C6C6C6C6C600000000;
      8'h4E:   return 128'h0000C6E6F6FEDECEC6C6C6C600000000;
      8'h4F:   return 128'h00007CC6C6C6C6C6C6C6C67C00000000;
      8'h52:   return 128'h0000FC6666667C6C666666E600000000;
      8'h53:   return 128'h00007CC6C660380C06C6C67C00000000;
      8'h55:   return 128'h0000C6C6C6C6C6C6C6C6C67C00000000;
      8'h56:   return 128'h0000C6C6C6C6C6C6C66C381000000000;
      8'h57:   return 128'h0000C6C6C6C6D6D6D6FEEE6C00000000;
      8'h59:   return 128'h0000666666663C181818183C00000000;
      default: return 128'h0;
    endcase
  endfunction

  function automatic logic [7:0] font_line(input logic [7:0] code, input logic [3:0] ln);
    logic [127:0] g;
    int           idx;
    g   = glyph(code);
    idx = 15 - int'(ln);
    return g[idx*8 +: 8];
  endfunction

  function automatic logic [31:0] expand4(input logic [7:0] b);
    logic [31:0] r;
    for (int i = 0; i < 8; i++)
      r[4*i +: 4] = {4{b[i]}};
    return r;
  endfunction

  function automatic logic [7:0] cell_code(input logic [3:0] row, input logic [3:0] col,
                                           input logic go, input logic vic,
                                           input logic [15:0] dig);
    logic [7:0] c;
    c = 8'h20;
    if (go && row == 4'd1) begin
      case (col)
        4'd4:    c = "G";
        4'd5:    c = "A";
        4'd6:    c = "M";
        4'd7:    c = "E";
        4'd9:    c = "O";
        4'd10:   c = "V";
        4'd11:   c = "E";
        4'd12:   c = "R";
        default: c = 8'h20;
      endcase
    end else if (vic && row == 4'd1) begin
      case (col)
        4'd5:    c = "Y";
        4'd6:    c = "O";
        4'd7:    c = "U";
        4'd9:    c = "W";
        4'd10:   c = "I";
        4'd11:   c = "N";
        default: c = 8'h20;
      endcase
    end else if ((go || vic) && row == 4'd3) begin
      case (col)
        4'd3:    c = "S";
        4'd4:    c = "C";
        4'd5:    c = "O";
        4'd6:    c = "R";
        4'd7:    c = "E";
        4'd9:    c = {4'h3, dig[15:12]};
        4'd10:   c = {4'h3, dig[11:8]};
        4'd11:   c = {4'h3, dig[7:4]};
        4'd12:   c = {4'h3, dig[3:0]};
        default: c = 8'h20;
      endcase
    end
    return c;
  endfunction

  state_t                state, state_nx;
  logic                  load_en, shift_en, done_en, busy;
  logic [SCORE_BITS-1:0] score_sat, last_val, bin_sh;
  logic [15:0]           bcd_sh, bcd_adj, digits;
  logic [CNT_W-1:0]      cnt;
  logic                  pending, go_q, vic_q;
  logic                  score_chg, start_edge;

  logic [7:0]            yx_p0, line_p0, code_p1;
  logic [3:0]            fline_p1;
  logic                  blank_p1;
  logic [31:0]           pixels_p2;
  logic                  unused_line_lsb;

  assign score_sat       = sat_score(bus.score);
  assign score_chg       = (score_sat != last_val);
  assign start_edge      = (bus.game_over & ~go_q) | (bus.victory & ~vic_q);
  assign bcd_adj         = dabble_adj(bcd_sh);
  assign unused_line_lsb = line_p0[0];

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (score_chg || start_edge) state_nx = LOAD;
      LOAD:    state_nx = SHIFT;
      SHIFT:   if (cnt == CNT_LAST) state_nx = DONE;
      DONE:    state_nx = (pending || score_chg) ? LOAD : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    load_en  = (state == LOAD);
    shift_en = (state == SHIFT);
    done_en  = (state == DONE);
  end

  // Digits change only in DONE, so the renderer never sees a half-shifted value.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      go_q     <= 1'b0;
      vic_q    <= 1'b0;
      last_val <= '0;
      bin_sh   <= '0;
      bcd_sh   <= '0;
      cnt      <= '0;
      pending  <= 1'b0;
      digits   <= '0;
    end else begin
      go_q  <= bus.game_over;
      vic_q <= bus.victory;
      if (load_en) begin
        bin_sh   <= score_sat;
        last_val <= score_sat;
        bcd_sh   <= '0;
        cnt      <= '0;
        pending  <= 1'b0;
      end else if (shift_en) begin
        bcd_sh <= {bcd_adj[14:0], bin_sh[SCORE_BITS-1]};
        bin_sh <= {bin_sh[SCORE_BITS-2:0], 1'b0};
        cnt    <= cnt + 1'b1;
        if (score_chg) pending <= 1'b1;
      end else if (done_en) begin
        digits <= bcd_sh;
      end
    end
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      yx_p0     <= '0;
      line_p0   <= '0;
      code_p1   <= '0;
      fline_p1  <= '0;
      blank_p1  <= 1'b0;
      pixels_p2 <= '0;
    end else begin
      // p0: sample the cell address
      yx_p0     <= bus.char_yx;
      line_p0   <= bus.char_line;
      // p1: cell -> ASCII code, font line index, out-of-cell blanking
      code_p1   <= cell_code(yx_p0[7:4], yx_p0[3:0], bus.game_over, bus.victory, digits);
      fline_p1  <= line_p0[4:1];
      blank_p1  <= |line_p0[7:5];
      // p2: font ROM read and 4x horizontal expansion
      pixels_p2 <= blank_p1 ? 32'h0 : expand4(font_line(code_p1, fline_p1));
    end
  end

  assign bus.char_pixels = pixels_p2;
  assign bus.bcd_busy    = busy;

endmodule
